stopwatch_counter: RTL and testbench

Timekeeping core of the stopwatch: divides the system clock down to a 100 Hz tick and counts elapsed time as six BCD digits, MM:SS.cc. It handles start/stop, clear and lap-freeze commands. Each registered digit output drives one `seg7` decoder instance downstream. Command inputs are single-cycle pulses that are already synchronised and debounced upstream.

---
 rtl/stopwatch_counter_if.sv | 10 +
 rtl/stopwatch_counter.sv | 66 ++++++
 tb/tb_stopwatch_counter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if: command pulses in, registered BCD display and status out
interface stopwatch_counter_if;
   logic       start_stop, clear, lap;
   logic [3:0] cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;
   logic       running, lap_active;
   modport master (output start_stop, clear, lap,
                   input cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens, running, lap_active);
   modport slave (input start_stop, clear, lap,
                  output cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens, running, lap_active);
endinterface

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: 100 Hz MM:SS.cc BCD stopwatch core with run/pause/clear/lap control
module stopwatch_counter #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 100
) (
   input logic clk,
   input logic rst,
   stopwatch_counter_if.slave sw
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   // wrap value per digit, index 0 = cs_ones ... 5 = m_tens
   localparam logic [3:0] LIM [6] = '{4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5};
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
   state_t        state, nxt;
   logic [PW-1:0] pre, pre_n;
   logic [3:0]    live [6], live_n [6], snap [6], snap_n [6], disp [6], disp_n [6];
   logic          counting, tick, run_q, lap_q;
   always_comb begin
      logic c;
      counting = state == RUN || state == LAP;
      tick = counting && pre == PW'(DIV - 1);
      case (state)
         IDLE:    nxt = sw.start_stop ? RUN : IDLE;
         RUN:     nxt = sw.start_stop ? PAUSE : sw.lap ? LAP : RUN;
         LAP:     nxt = sw.start_stop ? PAUSE : sw.lap ? RUN : LAP;
         default: nxt = sw.clear ? IDLE : sw.start_stop ? RUN : PAUSE;
      endcase
      pre_n = (nxt == IDLE || tick) ? '0 : counting ? pre + 1'b1 : pre;
      c = tick;
      for (int i = 0; i < 6; i++) begin
         live_n[i] = (nxt == IDLE) ? 4'd0 : c ? (live[i] == LIM[i] ? 4'd0 : live[i] + 4'd1) : live[i];
         c = c && live[i] == LIM[i];
         // snapshot takes the pre-tick value on entry to LAP
         snap_n[i] = (state == RUN && nxt == LAP) ? live[i] : snap[i];
         disp_n[i] = (nxt == LAP) ? snap_n[i] : live_n[i];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pre <= '0;
         live <= '{default: 4'd0};
         snap <= '{default: 4'd0};
         disp <= '{default: 4'd0};
         run_q <= 1'b0;
         lap_q <= 1'b0;
      end else begin
         state <= nxt;
         pre <= pre_n;
         live <= live_n;
         snap <= snap_n;
         disp <= disp_n;
         run_q <= nxt == RUN || nxt == LAP;
         lap_q <= nxt == LAP;
      end
   end
   assign sw.cs_ones = disp[0];
   assign sw.cs_tens = disp[1];
   assign sw.s_ones = disp[2];
   assign sw.s_tens = disp[3];
   assign sw.m_ones = disp[4];
   assign sw.m_tens = disp[5];
   assign sw.running = run_q;
   assign sw.lap_active = lap_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: scenario tasks plus random commands checked against an elapsed-centisecond model
module tb_stopwatch_counter;
   localparam int DIV = 10, DIV2 = 2;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   stopwatch_counter_if a ();
   stopwatch_counter_if b ();
   stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (.clk(clk), .rst(rst), .sw(a));
   stopwatch_counter #(.CLK_HZ(200), .TICK_HZ(100)) dut2 (.clk(clk), .rst(rst), .sw(b));
   logic [23:0] ga, gb;
   assign ga = {a.m_tens, a.m_ones, a.s_tens, a.s_ones, a.cs_tens, a.cs_ones};
   assign gb = {b.m_tens, b.m_ones, b.s_tens, b.s_ones, b.cs_tens, b.cs_ones};
   typedef struct {
      int t, ph, frz;
      bit idle, run, lap;
   } mdl_t;
   mdl_t ma, mb;
   int checks = 0, passed = 0;

   function automatic mdl_t mreset();
      mdl_t m;
      m.t = 0; m.ph = 0; m.frz = 0; m.idle = 1; m.run = 0; m.lap = 0;
      return m;
   endfunction

   // elapsed time kept as total centiseconds; phase counts cycles since the last tick
   function automatic mdl_t mstep(mdl_t m, int div, bit ss, bit cl, bit lp);
      bit cnt, tk;
      cnt = m.run;
      tk = m.run && m.ph == div - 1;
      if (m.idle) begin
         if (ss) begin m.idle = 0; m.run = 1; end
      end else if (!m.run) begin
         if (cl) m.idle = 1;
         else if (ss) m.run = 1;
      end else if (ss) begin
         m.run = 0; m.lap = 0;
      end else if (lp) begin
         if (!m.lap) m.frz = m.t;
         m.lap = !m.lap;
      end
      if (tk) begin m.t = (m.t + 1) % 360000; m.ph = 0; end
      else if (cnt) m.ph++;
      if (m.idle) begin m.t = 0; m.ph = 0; end
      return m;
   endfunction

   function automatic logic [23:0] bcd(int t);
      int cs, s, mm;
      cs = t % 100; s = (t / 100) % 60; mm = t / 6000;
      return {4'(mm / 10), 4'(mm % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
   endfunction

   function automatic logic [23:0] dispv(mdl_t m);
      return bcd(m.lap ? m.frz : m.t);
   endfunction

   task automatic cyc(input bit sa, input bit ca, input bit la, input bit sb, input bit r);
      a.start_stop = sa; a.clear = ca; a.lap = la; b.start_stop = sb; rst = r;
      @(posedge clk);
      ma = r ? mreset() : mstep(ma, DIV, sa, ca, la);
      mb = r ? mreset() : mstep(mb, DIV2, sb, 1'b0, 1'b0);
      #1;
      a.start_stop = 0; a.clear = 0; a.lap = 0; b.start_stop = 0; rst = 0;
   endtask

   task automatic test_reset();
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 1, 1);
      checks++;
      if (ga !== 24'h0 || a.running !== 1'b0 || a.lap_active !== 1'b0)
         $display("FAIL reset: got %h r%b l%b want 000000 r0 l0", ga, a.running, a.lap_active);
      else passed++;
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (ga !== 24'h0 || a.running !== 1'b0 || gb !== 24'h0 || b.running !== 1'b0)
         $display("FAIL reset_drop: got %h r%b / %h r%b want idle zeros", ga, a.running, gb, b.running);
      else passed++;
   endtask

   task automatic test_run();
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      for (int i = 1; i <= 1000; i++) begin
         cyc(0, 0, 0, 0, 0);
         checks++;
         if (ga !== dispv(ma) || a.running !== ma.run || a.lap_active !== ma.lap)
            $display("FAIL run c%0d: got %h r%b l%b want %h r%b l%b", i, ga, a.running, a.lap_active, dispv(ma), ma.run, ma.lap);
         else passed++;
      end
      checks++;
      if (ga !== 24'h000100 || a.running !== 1'b1)
         $display("FAIL run_1s: got %h r%b want 000100 r1", ga, a.running);
      else passed++;
   endtask

   task automatic test_lap();
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      repeat (55) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 100; i++) begin
         checks++;
         if (ga !== 24'h000005 || a.lap_active !== 1'b1 || a.running !== 1'b1)
            $display("FAIL lap_frozen c%0d: got %h r%b l%b want 000005 r1 l1", i, ga, a.running, a.lap_active);
         else passed++;
         cyc(0, 0, 0, 0, 0);
      end
      cyc(0, 0, 1, 0, 0);
      checks++;
      if (ga !== 24'h000015 || ga !== dispv(ma) || a.lap_active !== 1'b0 || a.running !== 1'b1)
         $display("FAIL lap_release: got %h r%b l%b want 000015 r1 l0", ga, a.running, a.lap_active);
      else passed++;
   endtask

   task automatic test_pause_clear();
      logic [23:0] held;
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      repeat (37) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      checks++;
      if (ga !== dispv(ma) || a.running !== 1'b1)
         $display("FAIL clear_in_run: got %h r%b want %h r1", ga, a.running, dispv(ma));
      else passed++;
      cyc(1, 0, 0, 0, 0);
      held = dispv(ma);
      for (int i = 0; i < 50; i++) begin
         cyc(0, 0, 0, 0, 0);
         checks++;
         if (ga !== held || a.running !== 1'b0 || ga !== 24'h000003)
            $display("FAIL pause_hold c%0d: got %h r%b want %h r0", i, ga, a.running, held);
         else passed++;
      end
      cyc(1, 1, 0, 0, 0);
      checks++;
      if (ga !== 24'h0 || a.running !== 1'b0 || a.lap_active !== 1'b0)
         $display("FAIL clear_prio: got %h r%b l%b want 000000 r0 l0", ga, a.running, a.lap_active);
      else passed++;
   endtask

   task automatic test_back_to_back();
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      repeat (9) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      checks++;
      if (ga !== 24'h000000 || a.lap_active !== 1'b1)
         $display("FAIL lap_on_tick: got %h l%b want 000000 l1", ga, a.lap_active);
      else passed++;
      cyc(0, 0, 1, 0, 0);
      checks++;
      if (ga !== 24'h000001 || a.lap_active !== 1'b0)
         $display("FAIL lap_no_lost_tick: got %h l%b want 000001 l0", ga, a.lap_active);
      else passed++;
      cyc(1, 0, 1, 0, 0);
      checks++;
      if (ga !== dispv(ma) || a.running !== 1'b0 || a.lap_active !== 1'b0)
         $display("FAIL ss_lap_prio: got %h r%b l%b want %h r0 l0", ga, a.running, a.lap_active, dispv(ma));
      else passed++;
   endtask

   task automatic test_rst_mid();
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      repeat (3470) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      checks++;
      if (ga !== 24'h000347 || a.lap_active !== 1'b1)
         $display("FAIL lap_347: got %h l%b want 000347 l1", ga, a.lap_active);
      else passed++;
      cyc(1, 0, 0, 0, 1);
      checks++;
      if (ga !== 24'h0 || a.running !== 1'b0 || a.lap_active !== 1'b0)
         $display("FAIL rst_mid: got %h r%b l%b want 000000 r0 l0", ga, a.running, a.lap_active);
      else passed++;
      repeat (12) cyc(0, 0, 0, 0, 0);
      checks++;
      if (ga !== 24'h0 || a.running !== 1'b0)
         $display("FAIL rst_idle_stays: got %h r%b want 000000 r0", ga, a.running);
      else passed++;
   endtask

   task automatic test_minute_carry();
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0);
      repeat (11998) cyc(0, 0, 0, 0, 0);
      checks++;
      if (gb !== 24'h005999 || gb !== dispv(mb))
         $display("FAIL pre_minute: got %h want 005999", gb);
      else passed++;
      repeat (2) cyc(0, 0, 0, 0, 0);
      checks++;
      if (gb !== 24'h010000 || b.running !== 1'b1)
         $display("FAIL minute_carry: got %h r%b want 010000 r1", gb, b.running);
      else passed++;
   endtask

   task automatic test_random();
      bit ss, cl, lp, r;
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         ss = $urandom_range(0, 9) == 0;
         cl = $urandom_range(0, 7) == 0;
         lp = $urandom_range(0, 7) == 0;
         r = $urandom_range(0, 299) == 0;
         cyc(ss, cl, lp, 0, r);
         checks++;
         if (ga !== dispv(ma) || a.running !== ma.run || a.lap_active !== ma.lap)
            $display("FAIL random c%0d: got %h r%b l%b want %h r%b l%b", i, ga, a.running, a.lap_active, dispv(ma), ma.run, ma.lap);
         else passed++;
      end
   endtask

   initial begin
      a.start_stop = 0; a.clear = 0; a.lap = 0;
      b.start_stop = 0; b.clear = 0; b.lap = 0;
      ma = mreset();
      mb = mreset();
      test_reset();
      test_run();
      test_lap();
      test_pause_clear();
      test_back_to_back();
      test_rst_mid();
      test_minute_carry();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
